// File: rtl/systolic_skew_feeder.sv
// Row-buffered operand feeder that streams a DIM x DIM tile into a systolic array with
// a one-cycle-per-lane diagonal skew. Optional stall input enabled by SKEW_FEEDER_STALL_EN.
module systolic_skew_feeder #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     WrRow,
  input  logic [DIM*BITS_AB-1:0]     WrData,
  input  logic                       start,
`ifdef SKEW_FEEDER_STALL_EN
  input  logic                       stall,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err,
  output logic                       en_out,
  output logic [DIM*BITS_AB-1:0]     Aout
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(2*DIM);
  localparam int W  = DIM*BITS_AB;
  localparam logic [CW-1:0] LAST = CW'(2*DIM-2);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_err_q, wr_err_d;
  logic          en_q, en_d;
  logic [W-1:0]  aout_q, aout_d;
  logic [W-1:0]  lanes_next;
  logic [W-1:0]  buf_q [DIM];
  logic [W-1:0]  buf_d [DIM];
  logic          stall_w;
  logic          emit;
  logic          hold;
  logic          wr_ok;

`ifdef SKEW_FEEDER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign wr_ok = WrEn && (state_q == IDLE);

  // buf_d is the post-write buffer, so a start coinciding with a write streams the new row.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
      assign buf_d[gi] = (wr_ok && (WrRow == RW'(gi))) ? WrData : buf_q[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    en_d     = 1'b0;
    done_d   = 1'b0;
    emit     = 1'b0;
    hold     = 1'b0;
    wr_err_d = WrEn && (state_q == STREAM);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          emit    = 1'b1;
        end
      end
      default: begin
        if (stall_w) begin
          busy_d = 1'b1;
          hold   = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
          en_d   = 1'b1;
          emit   = 1'b1;
        end
      end
    endcase
  end

  // Lane r shows column (t - r) of row r; diagonals outside the tile read as zero.
  always_comb begin
    lanes_next = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (cnt_d == CW'(r + c)) begin
          lanes_next[r*BITS_AB +: BITS_AB] = buf_d[r][c*BITS_AB +: BITS_AB];
        end
      end
    end
  end

  always_comb begin
    aout_d = '0;
    if (hold) begin
      aout_d = aout_q;
    end else if (emit) begin
      aout_d = lanes_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      en_q     <= 1'b0;
      aout_q   <= '0;
      for (int i = 0; i < DIM; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      en_q     <= en_d;
      aout_q   <= aout_d;
      for (int i = 0; i < DIM; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wr_err = wr_err_q;
  assign en_out = en_q;
  assign Aout   = aout_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (DIM=4, BITS_AB=8): vector table,
// directed corner sequences and randomized streams against a tile-level model.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WrEn;
  logic [1:0]  WrRow;
  logic [31:0] WrData;
  logic        start;
  logic        busy, done, wr_err, en_out;
  logic [31:0] Aout;
`ifdef SKEW_FEEDER_STALL_EN
  logic        stall;
`endif

  int vectors = 0;
  int miscompares = 0;
  int streams = 0;

  logic [7:0] mbuf [4][4];

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_row;
    logic [31:0] wr_data;
    logic        start;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DIM(4), .BITS_AB(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .WrEn   (WrEn),
    .WrRow  (WrRow),
    .WrData (WrData),
    .start  (start),
`ifdef SKEW_FEEDER_STALL_EN
    .stall  (stall),
`endif
    .busy   (busy),
    .done   (done),
    .wr_err (wr_err),
    .en_out (en_out),
    .Aout   (Aout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (busy,done,en,wr_err,Aout)", name, got, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {busy, done, en_out, wr_err, Aout};
  endfunction

  // Expected skewed operand word at stream step t, straight from the tile contents.
  function automatic logic [31:0] exp_aout(input int t);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      if (t - r >= 0 && t - r < 4) v[r*8 +: 8] = mbuf[r][t-r];
    end
    return v;
  endfunction

  task automatic set_row(input logic [1:0] row, input logic [31:0] data);
    for (int c = 0; c < 4; c++) mbuf[row][c] = data[c*8 +: 8];
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] row, input logic [31:0] d,
                              input logic st, input logic [3:0] flags, input logic [31:0] a);
    vec_t v;
    v.wr_en = we; v.wr_row = row; v.wr_data = d; v.start = st; v.exp = {flags, a};
    return v;
  endfunction

  task automatic write_row(input logic [1:0] row, input logic [31:0] data);
    WrEn = 1'b1; WrRow = row; WrData = data;
    set_row(row, data);
    step();
    WrEn = 1'b0;
    chk("wr_idle", {33'b0, busy, wr_err, en_out}, 36'b0);
  endtask

  task automatic load_pattern();
    for (int r = 0; r < 4; r++) begin
      logic [31:0] d;
      for (int c = 0; c < 4; c++) d[c*8 +: 8] = 8'(4*r + c + 1);
      write_row(2'(r), d);
    end
  endtask

  task automatic do_stream(input bit with_wr, input logic [1:0] row, input logic [31:0] data,
                           input bit rand_wr);
    logic prev_wr;
    start = 1'b1; WrEn = with_wr; WrRow = row; WrData = data;
    if (with_wr) set_row(row, data);
    step();
    start = 1'b0; WrEn = 1'b0; prev_wr = 1'b0;
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("stream t=%0d", t), outs(), {1'b1, 1'b0, 1'b1, prev_wr, exp_aout(t)});
      if (rand_wr) begin
        WrEn   = ($urandom_range(0, 2) == 0);
        WrRow  = 2'($urandom_range(0, 3));
        WrData = $urandom;
        start  = 1'($urandom_range(0, 1));
      end
      prev_wr = WrEn;
      step();
      start = 1'b0; WrEn = 1'b0;
    end
    chk("done", outs(), {1'b0, 1'b1, 1'b0, prev_wr, 32'h0});
    step();
    chk("after_done", outs(), 36'h0);
    streams++;
    $display("stream %0d checked (write_with_start=%0d)", streams, with_wr);
  endtask

  initial begin
    rst_n = 1'b0; WrEn = 1'b0; WrRow = '0; WrData = '0; start = 1'b0;
`ifdef SKEW_FEEDER_STALL_EN
    stall = 1'b0;
`endif
    tbl[0]  = mk(1, 2'd0, 32'h04030201, 0, 4'b0000, 32'h00000000);
    tbl[1]  = mk(1, 2'd1, 32'h08070605, 0, 4'b0000, 32'h00000000);
    tbl[2]  = mk(1, 2'd2, 32'h0C0B0A09, 0, 4'b0000, 32'h00000000);
    tbl[3]  = mk(1, 2'd3, 32'h100F0E0D, 0, 4'b0000, 32'h00000000);
    tbl[4]  = mk(0, 2'd0, 32'h0,        1, 4'b1010, 32'h00000001);
    tbl[5]  = mk(0, 2'd0, 32'h0,        0, 4'b1010, 32'h00000502);
    tbl[6]  = mk(0, 2'd0, 32'h0,        1, 4'b1010, 32'h00090603);
    tbl[7]  = mk(1, 2'd2, 32'hAAAAAAAA, 0, 4'b1011, 32'h0D0A0704);
    tbl[8]  = mk(0, 2'd0, 32'h0,        0, 4'b1010, 32'h0E0B0800);
    tbl[9]  = mk(0, 2'd0, 32'h0,        0, 4'b1010, 32'h0F0C0000);
    tbl[10] = mk(0, 2'd0, 32'h0,        0, 4'b1010, 32'h10000000);
    tbl[11] = mk(0, 2'd0, 32'h0,        0, 4'b0100, 32'h00000000);
    tbl[12] = mk(0, 2'd0, 32'h0,        0, 4'b0000, 32'h00000000);

    step(); step();
    chk("reset", outs(), 36'h0);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", outs(), 36'h0);

    for (int i = 0; i < 13; i++) begin
      WrEn = tbl[i].wr_en; WrRow = tbl[i].wr_row; WrData = tbl[i].wr_data; start = tbl[i].start;
      step();
      WrEn = 1'b0; start = 1'b0;
      chk($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
    end

    // Rejected mid-stream write must leave row 2 intact on replay.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mbuf[r][c] = 8'(4*r + c + 1);
    do_stream(0, 2'd0, 32'h0, 0);

    write_row(2'd0, 32'h01FF7F80);
    do_stream(0, 2'd0, 32'h0, 0);

    do_stream(1, 2'd0, 32'h09090909, 0);

    for (int it = 0; it < 15; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) write_row(2'($urandom_range(0, 3)), $urandom);
      do_stream(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1);
    end

`ifdef SKEW_FEEDER_STALL_EN
    begin
      int tseq [9] = '{0, 1, 2, 2, 2, 3, 4, 5, 6};
      bit eseq [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
      load_pattern();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("stall cyc=%0d", i), outs(), {1'b1, 1'b0, 1'(eseq[i]), 1'b0, exp_aout(tseq[i])});
        stall = (i == 2 || i == 3);
        step();
      end
      stall = 1'b0;
      chk("stall_done", outs(), {4'b0100, 32'h0});
      step();
    end
`endif

    // Asynchronous reset in the middle of a stream.
    load_pattern();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 3; t++) step();
    chk("pre_reset t=3", outs(), {4'b1010, exp_aout(3)});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 36'h0);
    step();
    chk("reset_hold", outs(), 36'h0);
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mbuf[r][c] = 8'h00;
    step();
    chk("no_autostart_0", outs(), 36'h0);
    step();
    chk("no_autostart_1", outs(), 36'h0);
    do_stream(0, 2'd0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
